// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a single FIFO.
// NUM_REQ producers compete for the FIFO write side. A winner owns the port
// for a burst of up to MAX_BURST words, so its packet lands contiguously.
//
// Handshake: producer i offers a word by holding req[i] high with
// req_data/req_last stable. The word is consumed in exactly the cycle in
// which gnt[i] is high. A word is only written when the FIFO is not full.
// gnt, fifo_wr_en and fifo_data are all combinational from the current
// state and inputs.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [OW-1:0]                 owner,
   output logic                          busy,
   output logic                          fifo_cs,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   input  logic                          fifo_full,
   output logic [15:0]                   wr_count
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_BURST - 1);
   localparam logic [OW-1:0] OWNER_LAST = OW'(NUM_REQ - 1);
   localparam logic [OW:0]   NUM_REQ_W  = (OW + 1)'(NUM_REQ);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [15:0]     wr_count_q, wr_count_d;

   logic [OW-1:0]         winner;
   logic                  found;
   logic [OW:0]           sum;
   logic [OW-1:0]         idx;
   logic                  owner_req;
   logic                  owner_last;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  accept;

   // Round-robin search: first requesting index at or above rr_ptr, wrapping.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (OW + 1)'(k);
         if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
         end
         idx = sum[OW-1:0];
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Mux out the current owner's request, end-of-packet flag and data word.
   always_comb begin
      owner_req  = 1'b0;
      owner_last = 1'b0;
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == OW'(i)) begin
            owner_req  = req[i];
            owner_last = req_last[i];
            owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state and output logic. While reset is asserted every output is
   // forced idle so a word offered in the reset cycle is never written.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      wr_count_d  = wr_count_q;
      gnt         = '0;
      busy        = 1'b0;
      fifo_cs     = 1'b0;
      fifo_wr_en  = 1'b0;
      fifo_data   = '0;
      accept      = 1'b0;
      if (reset) begin
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  owner_d     = winner;
                  burst_cnt_d = '0;
                  state_d     = S_BURST;
               end
            end
            S_BURST: begin
               fifo_cs = 1'b1;
               busy    = 1'b1;
               accept  = owner_req & ~fifo_full;
               if (accept) begin
                  gnt[owner_q] = 1'b1;
                  fifo_wr_en   = 1'b1;
                  fifo_data    = owner_data;
                  wr_count_d   = wr_count_q + 16'd1;
                  if (owner_last || (burst_cnt_q == CNT_LAST)) begin
                     state_d     = S_IDLE;
                     rr_ptr_d    = (owner_q == OWNER_LAST) ? '0 : owner_q + OW'(1);
                     burst_cnt_d = '0;
                  end else begin
                     burst_cnt_d = burst_cnt_q + CW'(1);
                  end
               end else if (!owner_req) begin
                  // Owner abandoned its burst: give the port up, nothing written.
                  state_d     = S_IDLE;
                  rr_ptr_d    = (owner_q == OWNER_LAST) ? '0 : owner_q + OW'(1);
                  burst_cnt_d = '0;
               end
               // Otherwise the FIFO is full: hold everything and wait.
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         wr_count_q  <= wr_count_d;
      end
   end

   assign owner    = owner_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word sources, a write
// monitor checking FIFO writes against an expected queue, and cycle-level
// checks of grant timing, stalls, abandons and reset.
module tb_fifo_wr_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int MB  = 4;
   localparam int OW  = 2;
   localparam int SRC_DEPTH = 32;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     gnt;
   logic [OW-1:0]     owner;
   logic              busy;
   logic              fifo_cs;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_data;
   logic              fifo_full;
   logic [15:0]       wr_count;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .req_last   (req_last),
      .gnt        (gnt),
      .owner      (owner),
      .busy       (busy),
      .fifo_cs    (fifo_cs),
      .fifo_wr_en (fifo_wr_en),
      .fifo_data  (fifo_data),
      .fifo_full  (fifo_full),
      .wr_count   (wr_count)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sources and scoreboard
   logic [DW-1:0]  src_data [NR][SRC_DEPTH];
   logic           src_last [NR][SRC_DEPTH];
   int             src_len  [NR];
   int             src_rd   [NR];
   logic [NR-1:0]  gnt_s;
   logic           next_reset;
   logic           next_full;

   logic [DW-1:0]  exp_q[$];
   logic [NR-1:0]  exp_gnt_q[$];

   int n_assert;
   int n_fail;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic load(input int r, input logic [DW-1:0] d, input logic l);
      src_data[r][src_len[r]] = d;
      src_last[r][src_len[r]] = l;
      src_len[r]++;
   endtask

   task automatic expect_w(input int r, input logic [DW-1:0] d);
      exp_q.push_back(d);
      exp_gnt_q.push_back(NR'(1) << r);
   endtask

   task automatic drive_src();
      for (int i = 0; i < NR; i++) begin
         if (src_rd[i] < src_len[i]) begin
            req[i]               = 1'b1;
            req_data[i*DW +: DW] = src_data[i][src_rd[i]];
            req_last[i]          = src_last[i][src_rd[i]];
         end else begin
            req[i]               = 1'b0;
            req_data[i*DW +: DW] = '0;
            req_last[i]          = 1'b0;
         end
      end
   endtask

   // Advance one clock: apply inputs just after the edge, then sample the
   // new cycle mid-period and check any FIFO write against the expected queue.
   task automatic tick();
      logic [DW-1:0] ed;
      logic [NR-1:0] eg;
      @(posedge clk);
      #1;
      reset     = next_reset;
      fifo_full = next_full;
      for (int i = 0; i < NR; i++) begin
         if (gnt_s[i]) src_rd[i]++;
      end
      drive_src();
      #5;
      gnt_s = gnt;
      if (fifo_wr_en === 1'b1) begin
         chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
         n_assert++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed data %0h expected no write", fifo_data);
         end
         if (exp_q.size() > 0) begin
            ed = exp_q.pop_front();
            eg = exp_gnt_q.pop_front();
            chk("wr_data", fifo_data, ed);
            chk("wr_gnt", {28'd0, gnt}, {28'd0, eg});
         end
      end else begin
         chk("idle_data_zero", fifo_data, 32'd0);
      end
   endtask

   task automatic wait_drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick();
         if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
      end
      chk(tag, exp_q.size(), 32'd0);
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      gnt_s      = '0;
      next_full  = 1'b0;
      next_reset = 1'b0;
      reset      = 1'b0;
      fifo_full  = 1'b0;
      req        = '0;
      req_data   = '0;
      req_last   = '0;
      for (int i = 0; i < NR; i++) begin
         src_len[i] = 0;
         src_rd[i]  = 0;
      end

      // 1. Reset held two clocks with all requesters active
      for (int r = 0; r < NR; r++) begin
         load(r, 32'hA0 + r, 1'b1);
         expect_w(r, 32'hA0 + r);
      end
      drive_src();
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_gnt", {28'd0, gnt}, 32'd0);
         chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
         chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      next_reset = 1'b1;
      tick();
      chk("post_rst_gnt", {28'd0, gnt}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("first_gnt", {28'd0, gnt}, 32'h1);
      chk("first_owner", {30'd0, owner}, 32'd0);
      chk("first_busy", {31'd0, busy}, 32'd1);
      wait_drain("drain_t1");
      chk("t1_wr_count", {16'd0, wr_count}, 32'd4);

      // 3. Round robin, all requesting, no last: forced release every MB words
      for (int r = 0; r < NR; r++) begin
         for (int k = 0; k < ((r == 0) ? 2 * MB : MB); k++) begin
            load(r, 32'h3000 + r * 256 + k, 1'b0);
         end
      end
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < MB; k++) begin
            expect_w(b % NR, 32'h3000 + (b % NR) * 256 + ((b == 4) ? MB : 0) + k);
         end
      end
      for (int b = 0; b < 5; b++) begin
         tick();
         chk("rr_idle_gnt", {28'd0, gnt}, 32'd0);
         if (b == 4) chk("rr_wr_count_16", {16'd0, wr_count}, 32'd20);
         for (int w = 0; w < MB; w++) begin
            tick();
            chk("rr_burst_gnt", {28'd0, gnt}, 32'd1 << (b % NR));
            chk("rr_owner", {30'd0, owner}, b % NR);
         end
      end
      tick();
      chk("rr_end_busy", {31'd0, busy}, 32'd0);
      chk("rr_end_wr_count", {16'd0, wr_count}, 32'd24);

      // 2. Single three-word packet from requester 1
      load(1, 32'h11, 1'b0);
      load(1, 32'h22, 1'b0);
      load(1, 32'h33, 1'b1);
      expect_w(1, 32'h11);
      expect_w(1, 32'h22);
      expect_w(1, 32'h33);
      tick();
      chk("pkt_arb_gnt", {28'd0, gnt}, 32'd0);
      for (int w = 0; w < 3; w++) begin
         tick();
         chk("pkt_gnt", {28'd0, gnt}, 32'h2);
      end
      tick();
      chk("pkt_end_busy", {31'd0, busy}, 32'd0);
      chk("pkt_wr_count", {16'd0, wr_count}, 32'd27);

      // 5. Abandon: requester 2 drops after one word, requester 3 waiting
      //    (rr_ptr must now be 2, so 2 wins over 3)
      load(2, 32'h2A, 1'b0);
      for (int k = 0; k < 4; k++) load(3, 32'h30 + k, (k == 3));
      expect_w(2, 32'h2A);
      for (int k = 0; k < 4; k++) expect_w(3, 32'h30 + k);
      tick();
      chk("ab_arb_gnt", {28'd0, gnt}, 32'd0);
      tick();
      chk("ab_gnt2", {28'd0, gnt}, 32'h4);
      tick();
      chk("ab_drop_gnt", {28'd0, gnt}, 32'd0);
      chk("ab_drop_busy", {31'd0, busy}, 32'd1);
      chk("ab_drop_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("ab_wr_count", {16'd0, wr_count}, 32'd28);
      tick();
      chk("ab_idle_busy", {31'd0, busy}, 32'd0);
      for (int w = 0; w < 4; w++) begin
         tick();
         chk("ab_gnt3", {28'd0, gnt}, 32'h8);
      end
      tick();
      chk("ab_end_busy", {31'd0, busy}, 32'd0);
      chk("ab_end_wr_count", {16'd0, wr_count}, 32'd32);

      // 4. Full stall for three cycles after the second word
      for (int k = 0; k < 6; k++) begin
         load(0, 32'h40 + k, 1'b0);
         expect_w(0, 32'h40 + k);
      end
      tick();
      chk("st_arb_gnt", {28'd0, gnt}, 32'd0);
      tick();
      chk("st_gnt_w0", {28'd0, gnt}, 32'h1);
      tick();
      chk("st_gnt_w1", {28'd0, gnt}, 32'h1);
      next_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("st_full_gnt", {28'd0, gnt}, 32'd0);
         chk("st_full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
         chk("st_full_busy", {31'd0, busy}, 32'd1);
      end
      next_full = 1'b0;
      tick();
      chk("st_gnt_w2", {28'd0, gnt}, 32'h1);
      tick();
      chk("st_gnt_w3", {28'd0, gnt}, 32'h1);
      tick();
      chk("st_burst_limit_idle", {28'd0, gnt}, 32'd0);
      chk("st_burst_limit_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("st_gnt_w4", {28'd0, gnt}, 32'h1);
      tick();
      chk("st_gnt_w5", {28'd0, gnt}, 32'h1);
      tick();
      chk("st_abandon_gnt", {28'd0, gnt}, 32'd0);
      chk("st_abandon_busy", {31'd0, busy}, 32'd1);
      wait_drain("drain_t4");
      chk("st_wr_count", {16'd0, wr_count}, 32'd38);

      // 6. Reset during the third word of a burst
      for (int k = 0; k < 4; k++) load(1, 32'h50 + k, 1'b0);
      load(0, 32'h60, 1'b1);
      expect_w(1, 32'h50);
      expect_w(1, 32'h51);
      expect_w(0, 32'h60);
      expect_w(1, 32'h52);
      expect_w(1, 32'h53);
      tick();
      chk("mr_arb_gnt", {28'd0, gnt}, 32'd0);
      tick();
      chk("mr_gnt_w0", {28'd0, gnt}, 32'h2);
      tick();
      chk("mr_gnt_w1", {28'd0, gnt}, 32'h2);
      next_reset = 1'b0;
      tick();
      chk("mr_rst_gnt", {28'd0, gnt}, 32'd0);
      chk("mr_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      next_reset = 1'b1;
      tick();
      chk("mr_after_wr_count", {16'd0, wr_count}, 32'd0);
      chk("mr_after_busy", {31'd0, busy}, 32'd0);
      chk("mr_after_owner", {30'd0, owner}, 32'd0);
      tick();
      chk("mr_regrant_0", {28'd0, gnt}, 32'h1);
      tick();
      chk("mr_idle_gnt", {28'd0, gnt}, 32'd0);
      tick();
      chk("mr_gnt_w2", {28'd0, gnt}, 32'h2);
      tick();
      chk("mr_gnt_w3", {28'd0, gnt}, 32'h2);
      wait_drain("drain_t6");
      chk("mr_wr_count", {16'd0, wr_count}, 32'd3);
      chk("exp_q_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
